// File: rtl/display_arbiter_if.sv
// ----------------------------------------------------------------------------
// display_arbiter_if
// Purpose : groups the requester-side and display-side signals of the shared
//           LED display arbiter into a single bundle.
// Signals : req[2:0]          per-requester level request
//           data0/1/2[7:0]    pattern offered by each requester
//           spin_display[7:0] pattern from the idle spinner
//           grant[2:0]        registered one-hot owner (0 when idle)
//           spin_enable       spinner enable, high while nobody owns
//           display[7:0]      shared LED pattern
// Modports: master -> drives requests/patterns, observes arbiter outputs
//           slave  -> the arbiter itself
// ----------------------------------------------------------------------------
interface display_arbiter_if;
    logic [2:0] req;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [7:0] data2;
    logic [7:0] spin_display;
    logic [2:0] grant;
    logic       spin_enable;
    logic [7:0] display;

    modport master (
        output req, data0, data1, data2, spin_display,
        input  grant, spin_enable, display
    );

    modport slave (
        input  req, data0, data1, data2, spin_display,
        output grant, spin_enable, display
    );
endinterface

// File: rtl/display_arbiter.sv
// ----------------------------------------------------------------------------
// display_arbiter
// Purpose : round-robin arbiter for a shared 8-bit LED display between three
//           requesters, with a minimum hold time before an active owner can be
//           preempted, and an idle spinner shown whenever nobody owns it.
// Ports   : i_clk    clock, all state on the rising edge
//           i_rst_n  asynchronous active-low reset
//           bus      display_arbiter_if.slave (requests, patterns, grant,
//                    spin_enable, display)
// Params  : HOLD_CYCLES  ownership cycles before preemption is allowed (>= 2)
// ----------------------------------------------------------------------------
module display_arbiter #(
    parameter int unsigned HOLD_CYCLES = 3_000_000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    display_arbiter_if.slave  bus
);
    localparam int unsigned CW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES - 1);

    typedef enum logic { S_IDLE, S_OWNED } state_t;

    state_t        r_state;
    logic [2:0]    r_grant;
    logic [1:0]    r_last;
    logic [CW-1:0] r_cnt;

    logic [2:0]    w_cand;
    logic [1:0]    w_win;
    logic          w_any_cand;
    logic          w_owner_req;

    // Candidates exclude the current owner. In IDLE r_grant is zero, so this
    // is the full request vector; when the owner has dropped its bit, masking
    // it changes nothing. One search serves every arbitration case.
    always_comb begin
        w_cand = bus.req & ~r_grant;
        w_win  = 2'd0;
        // Walk the order backwards so the nearest requester after r_last wins.
        for (int k = 3; k >= 1; k--) begin
            if (w_cand[(int'(r_last) + k) % 3])
                w_win = 2'((int'(r_last) + k) % 3);
        end
    end

    assign w_any_cand  = |w_cand;
    assign w_owner_req = |(bus.req & r_grant);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_grant <= 3'b000;
            r_last  <= 2'd2;    // requester 0 first after reset
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_cand) begin
                        r_state <= S_OWNED;
                        r_grant <= 3'b001 << w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                    end
                end
                S_OWNED: begin
                    if (!w_owner_req) begin
                        // Owner let go: hand over directly, or fall idle.
                        r_cnt <= '0;
                        if (w_any_cand) begin
                            r_grant <= 3'b001 << w_win;
                            r_last  <= w_win;
                        end else begin
                            r_state <= S_IDLE;
                            r_grant <= 3'b000;
                        end
                    end else if (r_cnt == CNT_MAX && w_any_cand) begin
                        r_grant <= 3'b001 << w_win;
                        r_last  <= w_win;
                        r_cnt   <= '0;
                    end else if (r_cnt != CNT_MAX) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 3'b000;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.grant       = r_grant;
    assign bus.spin_enable = i_rst_n && (r_state == S_IDLE);

    // Pure pass-through mux so owner data changes reach the LEDs in-cycle.
    always_comb begin
        bus.display = 8'h00;
        if (i_rst_n) begin
            if (r_state == S_IDLE) begin
                bus.display = bus.spin_display;
            end else begin
                case (r_grant)
                    3'b001:  bus.display = bus.data0;
                    3'b010:  bus.display = bus.data1;
                    3'b100:  bus.display = bus.data2;
                    default: bus.display = 8'h00;
                endcase
            end
        end
    end
endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 3_000_000, minimum ownership cycles before a held grant can be preempted; legal range >= 2.
REQ-002 clock  input  1  single clock for all state; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0); deassertion is synchronous to clock.
REQ-004 req  input  3  per-requester display request, bit i = requester i; level-sensitive.
REQ-005 data0, data1, data2  input  8 each  display pattern offered by requesters 0/1/2.
REQ-006 spin_display  input  8  pattern from the idle spinner.
REQ-007 grant  output  3  registered one-hot owner indication; all-zero when idle.
REQ-008 spin_enable  output  1  high when no requester owns the display; drives the spinner's enable.
REQ-009 display  output  8  shared 8-bit LED pattern.

Function
REQ-010 State machine has two states: IDLE (no owner) and OWNED (exactly one grant bit set).
REQ-011 grant shall be zero or one-hot at all times; any other value is a design error.
REQ-012 A last_owner register (2 bits, values 0..2) records the most recent owner and sets round-robin priority: search order starts at last_owner+1 mod 3.
REQ-013 IDLE with req != 0: next edge enters OWNED, grant = round-robin winner, last_owner = winner, hold counter = 0; one-cycle request-to-grant latency.
REQ-014 IDLE with req == 0: remain IDLE, grant = 0.
REQ-015 OWNED: hold counter increments each cycle, saturating at HOLD_CYCLES-1.
REQ-016 OWNED, owner's req bit dropped: next edge releases immediately regardless of counter; if another req is set, grant moves directly to its round-robin winner (counter = 0, no IDLE cycle); otherwise enter IDLE.
REQ-017 OWNED, owner still requesting, counter == HOLD_CYCLES-1, another req set: next edge grants the round-robin winner among the other requesters (counter = 0).
REQ-018 OWNED, owner still requesting, counter < HOLD_CYCLES-1 or no other req: hold grant unchanged.
REQ-019 Simultaneous requests: resolved only by round-robin order of REQ-012; requests arriving on the same edge as a switch are considered on that edge.
REQ-020 spin_enable = 1 iff state is IDLE and reset is deasserted.
REQ-021 display, combinational: OWNED -> data of the granted requester; IDLE -> spin_display; reset asserted -> 8'h00.
REQ-022 Changes to an owner's data are passed through to display in the same cycle, with no added latency.

Reset
REQ-023 While reset is 0: state = IDLE, grant = 3'b000, hold counter = 0, last_owner = 2 so that requester 0 has first priority, spin_enable = 0, display = 8'h00.
REQ-024 Reset asserted mid-ownership clears grant asynchronously; the first arbitration after release follows REQ-013 with last_owner = 2.

Verification (HOLD_CYCLES = 4)
REQ-025 Reset release, req=000, spin_display=8'h04 -> grant=000, spin_enable=1, display=8'h04.
REQ-026 req=111 from IDLE after reset -> next edge grant=001; held 4 cycles, then grant=010, 4 cycles later grant=100, then grant=001 (rotation).
REQ-027 grant=001, req changes 001->000 after 1 cycle -> next edge grant=000, spin_enable=1; with req=010 instead -> grant=010 directly, no idle cycle.
REQ-028 grant=010 with data1=8'hA5, then data1 changes to 8'h3C -> display follows in same cycle; data0 and data2 changes have no effect.
REQ-029 reset pulsed low while grant=100 -> grant=000 and display=8'h00 immediately; after release with req=110 -> grant=010.
REQ-030 Assertion on every cycle: grant is zero or one-hot, and spin_enable == (grant == 0) while reset is high.
